// File: rtl/dmem_responder.sv
// Doubleword data-memory responder: accepts one ld/sd request at a time from IDLE,
// runs WAIT_CYCLES wait states, then pulses ready (err flags rejected accesses).
// Ports: clk, rst_n (async, active-low); mem_read, mem_write, addr[63:0], wdata[63:0]
// in; rdata[63:0], ready, busy, err, rd_count[31:0], wr_count[31:0] out.
// Optional macro DMEM_PERF_EN adds saturating legal read/write response counters;
// without it rd_count and wr_count are tied to 0.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [63:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              rd_q;
  logic              wr_q;
  logic              bad_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] wd_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req;
  logic              bad_in;
  logic              in_idle;
  logic              cur_rd;
  logic              cur_wr;
  logic              cur_bad;
  logic [IW-1:0]     cur_idx;
  logic [DATA_W-1:0] cur_wd;
  logic              go_resp;
  logic              ok_rd;
  logic              ok_wr;

  assign req    = mem_read | mem_write;
  assign bad_in = (addr[2:0] != 3'd0)
                | (addr[63:3] >= 61'(DEPTH))
                | (mem_read & mem_write);

  // With zero wait states the response is issued straight from IDLE,
  // so the live inputs stand in for the latched request.
  assign in_idle = (state == IDLE);
  assign cur_rd  = in_idle ? mem_read  : rd_q;
  assign cur_wr  = in_idle ? mem_write : wr_q;
  assign cur_bad = in_idle ? bad_in    : bad_q;
  assign cur_idx = in_idle ? addr[IW+2:3] : idx_q;
  assign cur_wd  = in_idle ? wdata     : wd_q;

  assign go_resp = in_idle ? (req && (WAIT_CYCLES == 0))
                           : ((state == WAIT) && (cnt == LAST));
  assign ok_rd   = go_resp & cur_rd & ~cur_bad;
  assign ok_wr   = go_resp & cur_wr & ~cur_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      bad_q <= 1'b0;
      idx_q <= '0;
      wd_q  <= '0;
      rdata <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            rd_q  <= mem_read;
            wr_q  <= mem_write;
            bad_q <= bad_in;
            idx_q <= addr[IW+2:3];
            wd_q  <= wdata;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == LAST) state <= RESP;
          else cnt <= cnt + 1'b1;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (go_resp) begin
        ready <= 1'b1;
        err   <= cur_bad;
        // rdata is only disturbed by read responses and rejected
        // accesses; legal writes leave the last load data in place.
        if (cur_bad) rdata <= '0;
        else if (cur_rd) rdata <= mem[cur_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ok_wr) mem[cur_idx] <= cur_wd;
  end

`ifdef DMEM_PERF_EN
  logic [31:0] rdc;
  logic [31:0] wrc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdc <= '0;
      wrc <= '0;
    end else begin
      if (ok_rd && (rdc != 32'hFFFF_FFFF)) rdc <= rdc + 32'd1;
      if (ok_wr && (wrc != 32'hFFFF_FFFF)) wrc <= wrc + 32'd1;
    end
  end

  assign rd_count = rdc;
  assign wr_count = wrc;
`else
  assign rd_count = 32'd0;
  assign wr_count = 32'd0;
`endif

endmodule
